// File: rtl/gold_nic.sv
// PE-to-ring network interface: single-entry output and input channel buffers.
// Define NIC_PKT_CNT_EN to add tx/rx packet counters to the status registers.
module gold_nic #(
   parameter int PKT_W  = 64,
   parameter int VC_BIT = 63
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       addr,
   input  logic [PKT_W-1:0] d_in,
   output logic [PKT_W-1:0] d_out,
   input  logic             nicEn,
   input  logic             nicWrEn,
   output logic             net_so,
   input  logic             net_ro,
   output logic [PKT_W-1:0] net_do,
   input  logic             net_polarity,
   input  logic             net_si,
   output logic             net_ri,
   input  logic [PKT_W-1:0] net_di
);

   localparam logic [1:0] A_IN_BUF   = 2'd0;
   localparam logic [1:0] A_IN_STAT  = 2'd1;
   localparam logic [1:0] A_OUT_BUF  = 2'd2;
   localparam logic [1:0] A_OUT_STAT = 2'd3;

   logic             in_full_q,  in_full_d;
   logic             out_full_q, out_full_d;
   logic [PKT_W-1:0] in_buf_q,   in_buf_d;
   logic [PKT_W-1:0] out_buf_q,  out_buf_d;
   logic [PKT_W-1:0] d_out_q,    d_out_d;
   logic [PKT_W-1:0] in_stat,    out_stat;
   logic             pe_wr, pe_rd, capture;

   assign pe_wr   = nicEn & nicWrEn;
   assign pe_rd   = nicEn & ~nicWrEn;
   assign net_ri  = ~in_full_q;
   assign capture = net_si & ~in_full_q;
   // Send only when the packet's VC tag is opposite the router polarity.
   assign net_so  = out_full_q & net_ro & (out_buf_q[VC_BIT] != net_polarity);
   assign net_do  = out_buf_q;
   assign d_out   = d_out_q;

`ifdef NIC_PKT_CNT_EN
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      rx_cnt_d = rx_cnt_q;
      if (net_so)  tx_cnt_d = tx_cnt_q + 16'd1;
      if (capture) rx_cnt_d = rx_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
      end else begin
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end

   assign in_stat  = {32'b0, rx_cnt_q, 15'b0, in_full_q};
   assign out_stat = {32'b0, tx_cnt_q, 15'b0, out_full_q};
`else
   assign in_stat  = {{(PKT_W-1){1'b0}}, in_full_q};
   assign out_stat = {{(PKT_W-1){1'b0}}, out_full_q};
`endif

   always_comb begin
      out_full_d = out_full_q;
      out_buf_d  = out_buf_q;
      in_full_d  = in_full_q;
      in_buf_d   = in_buf_q;
      d_out_d    = d_out_q;

      // A write that meets a full buffer is dropped, even on the sending edge.
      if (net_so) begin
         out_full_d = 1'b0;
      end else if (pe_wr && addr == A_OUT_BUF && !out_full_q) begin
         out_full_d = 1'b1;
         out_buf_d  = d_in;
      end

      if (capture) begin
         in_full_d = 1'b1;
         in_buf_d  = net_di;
      end else if (pe_rd && addr == A_IN_BUF) begin
         in_full_d = 1'b0;
      end

      if (pe_rd) begin
         case (addr)
            A_IN_BUF:   d_out_d = in_buf_q;
            A_IN_STAT:  d_out_d = in_stat;
            A_OUT_STAT: d_out_d = out_stat;
            default:    d_out_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_full_q  <= 1'b0;
         out_full_q <= 1'b0;
         in_buf_q   <= '0;
         out_buf_q  <= '0;
         d_out_q    <= '0;
      end else begin
         in_full_q  <= in_full_d;
         out_full_q <= out_full_d;
         in_buf_q   <= in_buf_d;
         out_buf_q  <= out_buf_d;
         d_out_q    <= d_out_d;
      end
   end

endmodule

// File: tb/tb_gold_nic.sv
// Directed self-checking bench for gold_nic; polarity toggles one cycle at a time.
module tb_gold_nic;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic [63:0] d_in;
   logic [63:0] d_out;
   logic        nicEn, nicWrEn;
   logic        net_so, net_ro;
   logic [63:0] net_do;
   logic        net_polarity;
   logic        net_si, net_ri;
   logic [63:0] net_di;

   int checks = 0;
   int errors = 0;

   gold_nic dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
      .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
      .net_ri(net_ri), .net_di(net_di)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      net_polarity = ~net_polarity;
   endtask

   task automatic pe_write(input logic [1:0] a, input logic [63:0] data);
      addr = a; d_in = data; nicEn = 1'b1; nicWrEn = 1'b1;
      tick();
      nicEn = 1'b0; nicWrEn = 1'b0;
   endtask

   task automatic pe_read(input logic [1:0] a, output logic [63:0] data);
      addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
      tick();
      nicEn = 1'b0;
      data = d_out;
   endtask

   task automatic send_pkt(input logic [63:0] data);
      int n;
      net_ro = 1'b1;
      pe_write(2'd2, data);
      #1;
      n = 0;
      while (!net_so && n < 3) begin
         tick(); #1; n++;
      end
      chk("send_lat", {63'b0, (n < 2)}, 64'd1);
      chk("send_so", {63'b0, net_so}, 64'd1);
      tick();
      net_ro = 1'b0;
   endtask

   task automatic recv_pkt(input logic [63:0] data);
      logic [63:0] r;
      net_si = 1'b1; net_di = data;
      tick();
      net_si = 1'b0;
      pe_read(2'd0, r);
      chk("recv_data", r, data);
   endtask

   initial begin
      logic [63:0] r;
      reset = 1'b0; addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
      net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;

      // Reset values
      #2;
      chk("rst_so", {63'b0, net_so}, 64'd0);
      chk("rst_ri", {63'b0, net_ri}, 64'd1);
      chk("rst_dout", d_out, 64'd0);
      chk("rst_do", net_do, 64'd0);
      #1 reset = 1'b1;
      tick();

      // Send even packet: only during polarity=1
      net_ro = 1'b1;
      pe_write(2'd2, 64'h0000_0000_0000_00AA);
      #1;
      chk("even_do", net_do, 64'h0000_0000_0000_00AA);
      chk("even_so_pol", {63'b0, net_so}, {63'b0, net_polarity});
      if (!net_polarity) begin
         tick(); #1;
         chk("even_so_late", {63'b0, net_so}, 64'd1);
      end
      tick(); #1;
      chk("even_so_clr", {63'b0, net_so}, 64'd0);
      pe_read(2'd3, r);
      chk("even_stat", r, 64'd0);

      // Odd packet with backpressure, extra writes dropped
      net_ro = 1'b0;
      pe_write(2'd2, 64'h8000_0000_0000_0055);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_so", {63'b0, net_so}, 64'd0);
         tick();
      end
      pe_write(2'd2, 64'h0000_0000_0000_1234);
      #1;
      chk("bp_drop", net_do, 64'h8000_0000_0000_0055);
      net_ro = 1'b1;
      #1;
      chk("odd_so_pol", {63'b0, net_so}, {63'b0, ~net_polarity});
      if (net_polarity) begin
         tick(); #1;
         chk("odd_so_late", {63'b0, net_so}, 64'd1);
      end
      addr = 2'd2; d_in = 64'h0000_0000_0000_1234; nicEn = 1'b1; nicWrEn = 1'b1;
      tick();
      nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0;
      #1;
      chk("odd_so_clr", {63'b0, net_so}, 64'd0);
      chk("odd_do_keep", net_do, 64'h8000_0000_0000_0055);
      pe_read(2'd3, r);
      chk("send_wr_drop", r, 64'd0);

      // Receive path
      net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001;
      #1;
      chk("rx_ri0", {63'b0, net_ri}, 64'd1);
      tick();
      #1;
      chk("rx_ri_fall", {63'b0, net_ri}, 64'd0);
      net_di = 64'h0000_0000_0000_0BAD;
      tick();
      net_si = 1'b0;
      pe_read(2'd1, r);
      chk("rx_stat1", r, 64'd1);
      pe_read(2'd0, r);
      chk("rx_data", r, 64'hDEAD_BEEF_0000_0001);
      #1;
      chk("rx_ri_rise", {63'b0, net_ri}, 64'd1);
      pe_read(2'd1, r);
      chk("rx_stat0", r, 64'd0);
      pe_read(2'd0, r);
      chk("rx_stale", r, 64'hDEAD_BEEF_0000_0001);
      pe_read(2'd2, r);
      chk("rd_addr2", r, 64'd0);
      pe_write(2'd0, 64'h5555_5555_5555_5555);
      pe_write(2'd1, 64'h5555_5555_5555_5555);
      pe_read(2'd1, r);
      chk("wr0_ignored", r, 64'd0);
      pe_read(2'd0, r);
      chk("wr0_buf_keep", r, 64'hDEAD_BEEF_0000_0001);

      // Concurrent send and receive
      net_ro = 1'b0;
      pe_write(2'd2, 64'h0000_0000_0000_00CC);
      if (!net_polarity) tick();
      net_ro = 1'b1; net_si = 1'b1; net_di = 64'h0123_4567_89AB_CDEF;
      #1;
      chk("cc_so", {63'b0, net_so}, 64'd1);
      chk("cc_ri", {63'b0, net_ri}, 64'd1);
      tick();
      net_si = 1'b0; net_ro = 1'b0;
      #1;
      chk("cc_ri_after", {63'b0, net_ri}, 64'd0);
      pe_read(2'd3, r);
      chk("cc_out_stat", r, 64'd0);
      pe_read(2'd0, r);
      chk("cc_rx_data", r, 64'h0123_4567_89AB_CDEF);
      chk("cc_tx_data", net_do, 64'h0000_0000_0000_00CC);

      // Reset mid-transfer
      pe_write(2'd2, 64'h0000_0000_0000_0077);
      net_si = 1'b1; net_di = 64'h0000_0000_0000_0099;
      tick();
      net_si = 1'b0;
      pe_read(2'd1, r);
      chk("mid_in_full", r, 64'd1);
      pe_read(2'd3, r);
      chk("mid_out_full", r, 64'd1);
      if (!net_polarity) tick();
      net_ro = 1'b1;
      #1;
      chk("mid_so_pre", {63'b0, net_so}, 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_so_rst", {63'b0, net_so}, 64'd0);
      chk("mid_ri_rst", {63'b0, net_ri}, 64'd1);
      chk("mid_dout_rst", d_out, 64'd0);
      #1 reset = 1'b1; net_ro = 1'b0;
      pe_read(2'd1, r);
      chk("mid_in_stat", r, 64'd0);
      pe_read(2'd3, r);
      chk("mid_out_stat", r, 64'd0);

      // Packet counters (status upper bits stay 0 when counters absent)
      send_pkt(64'h0000_0000_0000_0001);
      send_pkt(64'h8000_0000_0000_0002);
      send_pkt(64'h0000_0000_0000_0003);
      recv_pkt(64'h0000_0000_0000_00A1);
      recv_pkt(64'h0000_0000_0000_00A2);
      pe_read(2'd3, r);
`ifdef NIC_PKT_CNT_EN
      chk("tx_cnt", r, 64'h0000_0000_0003_0000);
`else
      chk("tx_stat", r, 64'd0);
`endif
      pe_read(2'd1, r);
`ifdef NIC_PKT_CNT_EN
      chk("rx_cnt", r, 64'h0000_0000_0002_0000);
`else
      chk("rx_stat", r, 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
